// File: rtl/custom_mdu.sv
// Custom-opcode multi-cycle unit: iterative MULT and MODULO, single-cycle IS_EVEN.
// One request in flight; the response is held until the writeback consumer takes it.
module custom_mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      inst,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [6:0] OPC_CUSTOM = 7'b0001011;
   localparam logic [5:0] LAST_ITER  = 6'(WIDTH - 1);

   state_t           state;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             neg;

   logic [6:0]       opc;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [WIDTH-1:0] op1_mag;
   logic [WIDTH-1:0] op2_mag;
   logic [WIDTH-1:0] mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_sub;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] rem_signed;
   logic             unused_inst;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];
   assign unused_inst = ^{inst[24:15], inst[11:7]};

   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign resp_valid = (state == DONE);

   always_comb begin
      op1_mag  = operand1[WIDTH-1] ? (~operand1 + 1'b1) : operand1;
      op2_mag  = operand2[WIDTH-1] ? (~operand2 + 1'b1) : operand2;
      mul_sum  = mplier[0] ? (acc + mcand) : acc;
      // Restoring step: shift in the next dividend bit, subtract only if it fits.
      rem_sh   = {rem, dvd[WIDTH-1]};
      rem_sub  = rem_sh - {1'b0, dvs};
      rem_next = (rem_sh >= {1'b0, dvs}) ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      rem_signed = neg ? (~rem_next + 1'b1) : rem_next;
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state  <= IDLE;
         cnt    <= '0;
         result <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         rem    <= '0;
         dvd    <= '0;
         dvs    <= '0;
         neg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cnt <= '0;
                  if (opc == OPC_CUSTOM && f3 == 3'b111 && f7 == 7'b0000000) begin
                     acc    <= '0;
                     mcand  <= operand1;
                     mplier <= operand2;
                     state  <= MUL;
                  end else if (opc == OPC_CUSTOM && f3 == 3'b111 && f7 == 7'b0000001) begin
                     if (operand2 == '0) begin
                        result <= operand1;
                        state  <= DONE;
                     end else begin
                        rem   <= '0;
                        dvd   <= op1_mag;
                        dvs   <= op2_mag;
                        neg   <= operand1[WIDTH-1];
                        state <= DIV;
                     end
                  end else if (opc == OPC_CUSTOM && f3 == 3'b110) begin
                     result <= {{(WIDTH-1){1'b0}}, ~operand1[0]};
                     state  <= DONE;
                  end else begin
                     result <= '0;
                     state  <= DONE;
                  end
               end
            end
            MUL: begin
               acc    <= mul_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 6'd1;
               if (cnt == LAST_ITER) begin
                  result <= mul_sum;
                  state  <= DONE;
               end
            end
            DIV: begin
               rem <= rem_next;
               dvd <= dvd << 1;
               cnt <= cnt + 6'd1;
               if (cnt == LAST_ITER) begin
                  result <= rem_signed;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
